audio_frame_sequencer: RTL
==========================

// Module: audio_frame_sequencer
// PURPOSE
// Host-side sequencer for AudioProcessor. It turns a 16-bit sample stream (valid/ready) into a full
// frame of INPUT_SIZE-bit chunk writes, pulses start, and waits for the done flag to cycle. It then
// reads back every output chunk and re-serialises it as a 16-bit sample stream. It sits between the
// sample DMA/FIFO and AudioProcessor, and owns that block's data_wr_en/input_index/start/output_index.
// PARAMETERS
// SIZE        16    bits per sample
// INPUT_SIZE  512   bits per chunk (AudioProcessor data bus)
// SAMPLES     2048  samples per frame
// derived: SPC = INPUT_SIZE/SIZE (32) samples/chunk; CHUNKS = SAMPLES/SPC (64)
// PORTS
// clk               in   1           clock
// rst_n             in   1           async active-low reset
// in_valid          in   1           input sample valid
// in_sample         in   SIZE        input sample
// in_ready          out  1           sequencer accepts sample
// out_valid         out  1           output sample valid
// out_sample        out  SIZE        processed sample
// out_ready         in   1           consumer accepts sample
// ap_data_wr_en     out  1           -> AudioProcessor data_wr_en
// ap_input_index    out  log2(CHUNKS) -> input_index
// ap_data_in        out  INPUT_SIZE  -> data_in (packed chunk)
// ap_start          out  1           -> start (1-cycle pulse)
// ap_done           in   1           <- done (high while AudioProcessor idle)
// ap_output_index   out  log2(CHUNKS) -> output_index
// ap_data_out       in   INPUT_SIZE  <- data_out
// busy              out  1           frame handed to AudioProcessor, not yet read back
// frame_count       out  16          frames completed, wraps at 2^16
// BEHAVIOUR
// - One clock domain, clk. Reset is asynchronous and active-low on rst_n.
// - Reset: state FILL; all counters, pack/unpack regs and outputs 0; in_ready=1 after reset. Mid-frame reset drops the partial frame.
// - Packing: sample k of a chunk occupies bits [SIZE*k+SIZE-1 : SIZE*k]; sample 0 is the first accepted or emitted.
// - FSM (in audio_pkg):
//   FILL:  in_ready=1; each in_valid&in_ready stores a sample at slot k and increments k. At k=SPC-1 accept -> WRITE.
//   WRITE: one cycle with ap_data_wr_en=1, ap_input_index=chunk, ap_data_in=pack reg; k:=0.
//          chunk==CHUNKS-1 -> KICK with chunk:=0; else chunk++ -> FILL.
//   KICK:  ap_start=1 for exactly one cycle -> WAIT_BUSY.
//   WAIT_BUSY: wait for ap_done==0, then -> WAIT_DONE. Guards against sampling the pre-start idle done.
//   WAIT_DONE: ap_done==1 -> FETCH.
//   FETCH: ap_output_index=chunk. ap_data_out is valid one cycle later and is captured into the unpack reg -> DRAIN.
//          FETCH therefore takes 2 cycles: drive index, then capture.
//   DRAIN: out_valid=1, out_sample=slot k of the unpack reg. On out_valid&out_ready, k++.
//          At k=SPC-1 accept: k:=0. chunk==CHUNKS-1 -> FILL with chunk:=0 and frame_count++; else chunk++ -> FETCH.
// - in_ready=0 outside FILL; out_valid=0 outside DRAIN. The block is not double-buffered: input and output never overlap.
// - ap_output_index holds its last value outside FETCH/DRAIN. ap_input_index holds its value; only WRITE asserts wr_en.
// - busy=1 in KICK, WAIT_BUSY, WAIT_DONE; 0 elsewhere.
// - out_valid, once high, holds with a stable out_sample until accepted (no retraction).
// - in_valid while in_ready=0 is ignored, and the source must hold the sample.
// - Minimum frame latency from last input to first output = 1(WRITE)+1(KICK)+processing+2(FETCH) cycles.
// STRUCTURE
// - audio_pkg: seq_state_t enum {FILL,WRITE,KICK,WAIT_BUSY,WAIT_DONE,FETCH,DRAIN}, and SPC/CHUNKS localparams.
// - Sub-module chunk_shift_reg: a SPC x SIZE register with indexed write (pack) and indexed read (unpack).
//   Instantiated twice, once for pack and once for unpack.
// - Top holds the FSM, the k/chunk counters and the frame_count.
// TESTING (AudioProcessor replaced by behavioural model: done drops 1 cycle after start, rises N cycles later,
//          data_out = registered mem[output_index] with each sample +1)
// 1 Reset, then a 2048-sample ramp 0..2047 with in_valid=1 and out_ready=1 -> 64 wr_en pulses with indices 0..63;
//   chunk 0 bits[15:0]=0 and bits[511:496]=31; exactly one start pulse.
// 2 Model holds done=1 for 3 cycles after start before dropping -> no FETCH until done falls then rises; busy=1 throughout.
// 3 Readback with out_ready toggled 1010.. -> output stream 1..2048 in order, none lost or duplicated; frame_count=1.
// 4 in_valid held high during busy/DRAIN -> in_ready=0, no sample is consumed; the next frame starts cleanly at slot 0.
// 5 rst_n asserted after 1000 input samples -> all outputs 0 immediately. A fresh full frame then produces the correct indices 0..63.
// 6 Three back-to-back frames -> frame_count=3, and the second start occurs only after frame 1 has fully drained.

Source files
------------

// File: rtl/audio_frame_sequencer_pkg.sv
// Purpose: shared types and geometry for the audio frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   SIZE/INPUT_SIZE/SAMPLES fix the sample width, chunk width and frame length;
//   SPC and CHUNKS are derived from them.
package audio_frame_sequencer_pkg;

    localparam int SIZE       = 16;
    localparam int INPUT_SIZE = 512;
    localparam int SAMPLES    = 2048;
    localparam int SPC        = INPUT_SIZE / SIZE;   // samples per chunk
    localparam int CHUNKS     = SAMPLES / SPC;       // chunks per frame
    localparam int K_W        = $clog2(SPC);
    localparam int IDX_W      = $clog2(CHUNKS);

    typedef logic [SIZE-1:0]       sample_t;
    typedef logic [INPUT_SIZE-1:0] chunk_t;

    typedef enum logic [2:0] {
        FILL,
        WRITE,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        FETCH,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/audio_frame_sequencer_if.sv
// Purpose: sample-stream and AudioProcessor signals of the frame sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sample streams; AudioProcessor side is index/strobe.
//   master = sequencer side, slave = sample source/sink plus AudioProcessor.
interface audio_frame_sequencer_if;
    import audio_frame_sequencer_pkg::*;

    logic             in_valid;
    sample_t          in_sample;
    logic             in_ready;
    logic             out_valid;
    sample_t          out_sample;
    logic             out_ready;
    logic             ap_data_wr_en;
    logic [IDX_W-1:0] ap_input_index;
    chunk_t           ap_data_in;
    logic             ap_start;
    logic             ap_done;
    logic [IDX_W-1:0] ap_output_index;
    chunk_t           ap_data_out;

    modport master (
        input  in_valid, in_sample, out_ready, ap_done, ap_data_out,
        output in_ready, out_valid, out_sample, ap_data_wr_en, ap_input_index,
               ap_data_in, ap_start, ap_output_index
    );

    modport slave (
        output in_valid, in_sample, out_ready, ap_done, ap_data_out,
        input  in_ready, out_valid, out_sample, ap_data_wr_en, ap_input_index,
               ap_data_in, ap_start, ap_output_index
    );

endinterface

// File: rtl/audio_frame_sequencer_chunk_shift_reg.sv
// Purpose: SPC x SIZE sample register; per-slot write (packing) or whole-chunk load (unpacking).
// Latency: write/load visible the cycle after; rd_dat is combinational from idx.
// Backpressure: none; the owner decides when to write or load.
//   Ports: load/load_dat parallel load, wr_en/wr_dat slot write at idx,
//   rd_dat slot read at idx, q whole chunk (slot k at bits [SIZE*k +: SIZE]).
module audio_frame_sequencer_chunk_shift_reg
    import audio_frame_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  chunk_t         load_dat,
    input  logic           wr_en,
    input  logic [K_W-1:0] idx,
    input  sample_t        wr_dat,
    output sample_t        rd_dat,
    output chunk_t         q
);

    logic [SPC-1:0][SIZE-1:0] slots;

    // Load wins over a slot write; the two are never used on the same instance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
        end else if (load) begin
            slots <= load_dat;
        end else if (wr_en) begin
            slots[idx] <= wr_dat;
        end
    end

    assign rd_dat = slots[idx];
    assign q      = slots;

endmodule

// File: rtl/audio_frame_sequencer.sv
// Purpose: packs a 16-bit sample stream into AudioProcessor chunks, kicks it, then streams results back.
// Latency: last input -> first output = WRITE + KICK + processing + 2-cycle FETCH.
// Backpressure: in_ready only in FILL; out_valid only in DRAIN and held until out_ready.
//   Ports: clk, rst_n; bus (master modport) carries both sample streams and the
//   AudioProcessor controls; busy marks a frame owned by AudioProcessor; frame_count
//   counts fully drained frames and wraps.
module audio_frame_sequencer
    import audio_frame_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    audio_frame_sequencer_if.master bus,
    output logic                   busy,
    output logic [15:0]            frame_count
);

    seq_state_t       state, state_n;
    logic [K_W-1:0]   k, k_n;
    logic [IDX_W-1:0] chunk, chunk_n;
    logic [IDX_W-1:0] in_idx_q, out_idx_q;
    logic             fetch_cap, fetch_cap_n;
    logic [15:0]      frame_count_n;

    logic    pack_wr, unpack_load;
    logic    in_rdy, out_vld, wr_en, start;
    chunk_t  pack_q;
    sample_t unpack_rd;
    sample_t pack_rd_unused;
    chunk_t  unpack_q_unused;

    audio_frame_sequencer_chunk_shift_reg u_pack (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_dat ('0),
        .wr_en    (pack_wr),
        .idx      (k),
        .wr_dat   (bus.in_sample),
        .rd_dat   (pack_rd_unused),
        .q        (pack_q)
    );

    audio_frame_sequencer_chunk_shift_reg u_unpack (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (unpack_load),
        .load_dat (bus.ap_data_out),
        .wr_en    (1'b0),
        .idx      (k),
        .wr_dat   ('0),
        .rd_dat   (unpack_rd),
        .q        (unpack_q_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            k           <= '0;
            chunk       <= '0;
            fetch_cap   <= 1'b0;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            chunk       <= chunk_n;
            fetch_cap   <= fetch_cap_n;
            frame_count <= frame_count_n;
            if (state == WRITE) in_idx_q  <= chunk;
            if (state == FETCH) out_idx_q <= chunk;
        end
    end

    always_comb begin
        state_n       = state;
        k_n           = k;
        chunk_n       = chunk;
        fetch_cap_n   = 1'b0;
        frame_count_n = frame_count;
        pack_wr       = 1'b0;
        unpack_load   = 1'b0;
        in_rdy        = 1'b0;
        out_vld       = 1'b0;
        wr_en         = 1'b0;
        start         = 1'b0;
        busy          = 1'b0;
        case (state)
            FILL: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    pack_wr = 1'b1;
                    k_n     = k + 1'b1;
                    if (k == K_W'(SPC - 1)) state_n = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                k_n   = '0;
                if (chunk == IDX_W'(CHUNKS - 1)) begin
                    chunk_n = '0;
                    state_n = KICK;
                end else begin
                    chunk_n = chunk + 1'b1;
                    state_n = FILL;
                end
            end
            KICK: begin
                start   = 1'b1;
                busy    = 1'b1;
                state_n = WAIT_BUSY;
            end
            // done is still high from the idle period when start lands; only a
            // falling edge proves the processor has taken the frame.
            WAIT_BUSY: begin
                busy = 1'b1;
                if (!bus.ap_done) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (bus.ap_done) state_n = FETCH;
            end
            // First cycle presents the index, second captures the registered read data.
            FETCH: begin
                if (!fetch_cap) begin
                    fetch_cap_n = 1'b1;
                end else begin
                    unpack_load = 1'b1;
                    state_n     = DRAIN;
                end
            end
            DRAIN: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    k_n = k + 1'b1;
                    if (k == K_W'(SPC - 1)) begin
                        k_n = '0;
                        if (chunk == IDX_W'(CHUNKS - 1)) begin
                            chunk_n       = '0;
                            frame_count_n = frame_count + 16'd1;
                            state_n       = FILL;
                        end else begin
                            chunk_n = chunk + 1'b1;
                            state_n = FETCH;
                        end
                    end
                end
            end
            default: state_n = FILL;
        endcase
    end

    assign bus.in_ready        = in_rdy;
    assign bus.out_valid       = out_vld;
    assign bus.out_sample      = (state == DRAIN) ? unpack_rd : '0;
    assign bus.ap_data_wr_en   = wr_en;
    assign bus.ap_start        = start;
    assign bus.ap_data_in      = pack_q;
    // Indices are live while their phase drives them and hold their last value otherwise.
    assign bus.ap_input_index  = (state == WRITE) ? chunk : in_idx_q;
    assign bus.ap_output_index = (state == FETCH) ? chunk : out_idx_q;

endmodule
